// File: rtl/toggle_event_rx.sv
// Toggle-encoded event receiver: synchronizes an async toggle line,
// turns each level change into an event and queues it for a consumer.
module toggle_event_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_MAX    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tgl_in,
  input  logic                           evt_ready,
  input  logic                           clr_ovf,
  output logic                           evt_pulse,
  output logic                           evt_valid,
  output logic [$clog2(PEND_MAX+1)-1:0]  pend_cnt,
  output logic [7:0]                     evt_total,
  output logic                           ovf
);

  localparam int PW = $clog2(PEND_MAX + 1);
  localparam int CW = $clog2(SYNC_STAGES + 1);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state;
  logic [CW-1:0]          init_cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   tgl_s;
  logic                   tgl_d;
  logic                   edge_det;
  logic                   hs;
  logic                   full;
  logic                   drop;
  logic [PW-1:0]          pend_nxt;

  assign tgl_s = sync[SYNC_STAGES-1];

  // Synchronizer chain for the asynchronous toggle line
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], tgl_in};
    end
  end

  // Delayed copy; tracking it in INIT makes the release level the baseline
  always_ff @(posedge clk) begin
    if (!rst) begin
      tgl_d <= 1'b0;
    end else begin
      tgl_d <= tgl_s;
    end
  end

  // INIT masks edges until the chain and tgl_d have settled, then RUN forever
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      unique case (state)
        INIT: begin
          if (init_cnt == CW'(SYNC_STAGES)) begin
            state <= RUN;
          end else begin
            init_cnt <= init_cnt + CW'(1);
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  assign edge_det = (state == RUN) && (tgl_s ^ tgl_d);
  assign hs       = evt_valid & evt_ready;
  assign full     = (pend_cnt == PW'(PEND_MAX));
  assign drop     = edge_det & ~hs & full;

  // Next pending count: an edge and a handshake in one cycle cancel out
  always_comb begin
    pend_nxt = pend_cnt;
    unique case (1'b1)
      (edge_det & ~hs & ~full): pend_nxt = pend_cnt + PW'(1);
      (~edge_det & hs):         pend_nxt = pend_cnt - PW'(1);
      default:                  pend_nxt = pend_cnt;
    endcase
  end

  // Pending queue depth and its registered valid flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_cnt  <= '0;
      evt_valid <= 1'b0;
    end else begin
      pend_cnt  <= pend_nxt;
      evt_valid <= (pend_nxt != '0);
    end
  end

  // One-cycle strobe per detected edge, dropped ones included
  always_ff @(posedge clk) begin
    if (!rst) begin
      evt_pulse <= 1'b0;
    end else begin
      evt_pulse <= edge_det;
    end
  end

  // Saturating total of every detected edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      evt_total <= '0;
    end else if (edge_det && (evt_total != 8'hFF)) begin
      evt_total <= evt_total + 8'd1;
    end
  end

  // Sticky overflow; a drop in the clearing cycle keeps it set
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_toggle_event_rx.sv
// Bench for toggle_event_rx: directed scenarios plus a random run
// compared against a scheduled-event reference model.
module tb_toggle_event_rx;

  localparam int SS = 2;
  localparam int PEND_MAX = 4;
  localparam int PW = $clog2(PEND_MAX + 1);

  logic          clk;
  logic          rst;
  logic          tgl_in;
  logic          evt_ready;
  logic          clr_ovf;
  logic          evt_pulse;
  logic          evt_valid;
  logic [PW-1:0] pend_cnt;
  logic [7:0]    evt_total;
  logic          ovf;

  int n_chk;
  int n_fail;

  int m_pend;
  int m_total;
  bit m_ovf;
  bit m_pulse;
  int ecnt;
  int since_rel;
  int q[$];

  toggle_event_rx #(
    .SYNC_STAGES(SS),
    .PEND_MAX(PEND_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tgl_in(tgl_in),
    .evt_ready(evt_ready),
    .clr_ovf(clr_ovf),
    .evt_pulse(evt_pulse),
    .evt_valid(evt_valid),
    .pend_cnt(pend_cnt),
    .evt_total(evt_total),
    .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; the model applies the event rules at that edge
  task automatic tick();
    bit det;
    bit hs;
    bit drop;
    @(posedge clk);
    ecnt++;
    if (!rst) begin
      m_pend = 0;
      m_total = 0;
      m_ovf = 0;
      m_pulse = 0;
      since_rel = 0;
      q.delete();
    end else begin
      since_rel++;
      det = 0;
      if (q.size() > 0 && q[0] == ecnt) begin
        det = 1;
        void'(q.pop_front());
      end
      hs = (m_pend != 0) && evt_ready;
      drop = det && !hs && (m_pend == PEND_MAX);
      if (det && m_total < 255) m_total++;
      if (det && !hs && !drop) m_pend++;
      else if (!det && hs) m_pend--;
      if (drop) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      m_pulse = det;
    end
    #1;
  endtask

  // Flip the line; a change before the 2nd post-release edge is baseline
  task automatic toggle();
    tgl_in = ~tgl_in;
    if (rst && (since_rel + 1) >= 2)
      q.push_back(ecnt + 1 + SS);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (SS + 3) tick();
  endtask

  task automatic test_reset();
    bit seen;
    rst = 1'b0;
    tgl_in = 1'b1;
    repeat (3) tick();
    n_chk++;
    if ({evt_pulse, evt_valid, ovf} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000",
               {evt_pulse, evt_valid, ovf});
    end
    n_chk++;
    if (pend_cnt !== '0 || evt_total !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_counts: got pend=%0d total=%0d expected 0/0",
               pend_cnt, evt_total);
    end
    rst = 1'b1;
    seen = 0;
    repeat (10) begin
      tick();
      if (evt_pulse !== 1'b0) seen = 1;
    end
    n_chk++;
    if (seen) begin
      n_fail++;
      $display("FAIL baseline_pulse: got pulse high expected never");
    end
    n_chk++;
    if (evt_valid !== 1'b0 || evt_total !== 8'd0) begin
      n_fail++;
      $display("FAIL baseline_state: got valid=%0b total=%0d expected 0/0",
               evt_valid, evt_total);
    end
  endtask

  task automatic test_single_event();
    bit exp;
    evt_ready = 1'b0;
    toggle();
    for (int i = 0; i < SS + 2; i++) begin
      tick();
      exp = (i == SS);
      n_chk++;
      if (evt_pulse !== exp) begin
        n_fail++;
        $display("FAIL latency_edge%0d: got %0b expected %0b",
                 i, evt_pulse, exp);
      end
    end
    n_chk++;
    if (pend_cnt !== PW'(1) || evt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_pend: got pend=%0d valid=%0b expected 1/1",
               pend_cnt, evt_valid);
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_chk++;
    if (pend_cnt !== '0 || evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ack: got pend=%0d valid=%0b expected 0/0",
               pend_cnt, evt_valid);
    end
    tick();
    n_chk++;
    if (pend_cnt !== PW'(m_pend) || evt_total !== 8'(m_total)) begin
      n_fail++;
      $display("FAIL single_model: got pend=%0d total=%0d expected %0d/%0d",
               pend_cnt, evt_total, m_pend, m_total);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    evt_ready = 1'b0;
    repeat (5) begin
      toggle();
      repeat (3) tick();
    end
    repeat (SS + 1) tick();
    n_chk++;
    if (pend_cnt !== PW'(4) || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got pend=%0d ovf=%0b expected 4/1",
               pend_cnt, ovf);
    end
    n_chk++;
    if (evt_total !== 8'd5) begin
      n_fail++;
      $display("FAIL ovf_total: got %0d expected 5", evt_total);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_chk++;
    if (ovf !== 1'b0 || pend_cnt !== PW'(4)) begin
      n_fail++;
      $display("FAIL ovf_clear: got ovf=%0b pend=%0d expected 0/4",
               ovf, pend_cnt);
    end
  endtask

  task automatic test_full_accept();
    toggle();
    repeat (SS) tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_chk++;
    if (evt_pulse !== 1'b1 || pend_cnt !== PW'(4) || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL full_accept: got pulse=%0b pend=%0d ovf=%0b expected 1/4/0",
               evt_pulse, pend_cnt, ovf);
    end
    n_chk++;
    if (evt_total !== 8'd6) begin
      n_fail++;
      $display("FAIL full_total: got %0d expected 6", evt_total);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    evt_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      toggle();
      repeat (3) tick();
      if (i == 150) begin
        n_chk++;
        if (evt_total !== 8'(m_total)) begin
          n_fail++;
          $display("FAIL sat_mid: got %0d expected %0d",
                   evt_total, m_total);
        end
      end
    end
    repeat (SS + 2) tick();
    evt_ready = 1'b0;
    n_chk++;
    if (evt_total !== 8'd255 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL saturate: got total=%0d ovf=%0b expected 255/0",
               evt_total, ovf);
    end
    n_chk++;
    if (pend_cnt !== '0 || evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_drain: got pend=%0d valid=%0b expected 0/0",
               pend_cnt, evt_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    do_reset();
    evt_ready = 1'b0;
    repeat (3) begin
      toggle();
      repeat (3) tick();
    end
    repeat (SS) tick();
    n_chk++;
    if (pend_cnt !== PW'(3) || evt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pend: got pend=%0d valid=%0b expected 3/1",
               pend_cnt, evt_valid);
    end
    rst = 1'b0;
    tick();
    n_chk++;
    if (pend_cnt !== '0 || evt_valid !== 1'b0 ||
        evt_total !== 8'd0 || ovf !== 1'b0 || evt_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got pend=%0d valid=%0b total=%0d ovf=%0b expected 0",
               pend_cnt, evt_valid, evt_total, ovf);
    end
    rst = 1'b1;
    toggle();
    seen = 0;
    repeat (12) begin
      tick();
      if (evt_pulse !== 1'b0) seen = 1;
    end
    n_chk++;
    if (seen || evt_total !== 8'd0 || evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL init_toggle: got seen=%0b total=%0d valid=%0b expected 0",
               seen, evt_total, evt_valid);
    end
  endtask

  task automatic test_random();
    int gap;
    int errs;
    do_reset();
    gap = 10;
    errs = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) != 0);
      evt_ready = ($urandom_range(0, 2) == 0);
      clr_ovf = ($urandom_range(0, 15) == 0);
      if (gap >= 2 && $urandom_range(0, 2) == 0) begin
        toggle();
        gap = 0;
      end else begin
        gap++;
      end
      tick();
      n_chk++;
      if (evt_pulse !== m_pulse || evt_valid !== (m_pend != 0) ||
          pend_cnt !== PW'(m_pend) || evt_total !== 8'(m_total) ||
          ovf !== m_ovf) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_c%0d: got p=%0b v=%0b n=%0d t=%0d o=%0b expected p=%0b n=%0d t=%0d o=%0b",
                   i, evt_pulse, evt_valid, pend_cnt, evt_total, ovf,
                   m_pulse, m_pend, m_total, m_ovf);
      end
    end
    rst = 1'b1;
    evt_ready = 1'b0;
    clr_ovf = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    m_pend = 0;
    m_total = 0;
    m_ovf = 0;
    m_pulse = 0;
    ecnt = 0;
    since_rel = 0;
    rst = 1'b0;
    tgl_in = 1'b0;
    evt_ready = 1'b0;
    clr_ovf = 1'b0;
    test_reset();
    test_single_event();
    test_overflow();
    test_full_accept();
    test_saturate();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/toggle_event_rx.md
TOGGLE_EVENT_RX -- requirements
Module: toggle_event_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of synchronizer flops on tgl_in (legal 2..4).
REQ-002 Parameter PEND_MAX, default 4, SHALL set the maximum number of pending (unacknowledged) events (legal 1..15).
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the reset: synchronous, active-low.
REQ-005 Port tgl_in, input, 1, SHALL be the toggle-encoded event line; every level change is one event; asynchronous to clk.
REQ-006 Port evt_ready, input, 1, SHALL be the consumer acknowledge.
REQ-007 Port clr_ovf, input, 1, SHALL clear the sticky overflow flag.
REQ-008 Port evt_pulse, output, 1, SHALL be a registered one-cycle strobe per detected event.
REQ-009 Port evt_valid, output, 1, SHALL indicate at least one pending event.
REQ-010 Port pend_cnt, output, clog2(PEND_MAX+1), SHALL be the pending-event count.
REQ-011 Port evt_total, output, 8, SHALL be the saturating count of detected events.
REQ-012 Port ovf, output, 1, SHALL be the sticky flag for dropped events.

Function
REQ-013 tgl_in SHALL pass through SYNC_STAGES flops; the last stage is tgl_s, and tgl_d is tgl_s delayed one cycle.
REQ-014 A detected edge SHALL be (tgl_s XOR tgl_d) while the state is RUN; it is masked in INIT.
REQ-015 The state machine SHALL have two states: INIT (entered at reset), then RUN after SYNC_STAGES+1 cycles, with RUN held until the next reset.
REQ-016 In INIT, tgl_d SHALL track tgl_s, so the line level at reset release is the baseline and is never counted.
REQ-017 Latency: if tgl_in changes before edge k (RUN), evt_pulse SHALL be high for exactly the cycle after edge k+SYNC_STAGES; with default parameters, the cycle after edge k+2.
REQ-018 A handshake SHALL occur when evt_valid and evt_ready are both high at a rising edge.
REQ-019 evt_valid SHALL equal (pend_cnt != 0), and SHALL stay high until handshakes drain pend_cnt.
REQ-020 pend_cnt SHALL update as follows:
- +1 on a detected edge.
- -1 on a handshake.
- Unchanged when both occur in the same cycle.
REQ-021 A detected edge with pend_cnt == PEND_MAX and no handshake in the same cycle SHALL be dropped: pend_cnt stays PEND_MAX and ovf is set.
REQ-022 A detected edge with pend_cnt == PEND_MAX and a handshake in the same cycle SHALL be accepted: pend_cnt stays PEND_MAX and ovf is not set.
REQ-023 evt_ready while evt_valid is low SHALL have no effect.
REQ-024 evt_total SHALL increment on every detected edge, including dropped ones, and SHALL saturate at 255 without wrapping.
REQ-025 ovf SHALL remain set until clr_ovf is high at a rising edge; if set and clear coincide, set wins.
REQ-026 Toggles closer than one clk period after synchronization MAY be merged; this is a documented limitation, not an error.

Reset
REQ-027 While rst is low at a rising edge, the block SHALL set:
- all sync flops and tgl_d to 0;
- state to INIT;
- evt_pulse 0, evt_valid 0, pend_cnt 0, evt_total 0, ovf 0.
REQ-028 Reset asserted mid-operation SHALL discard pending events and restart INIT; outputs SHALL be at reset values in the cycle after that edge.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Hold tgl_in=1 through reset, release, wait 10 cycles -> evt_pulse never high, evt_valid 0, evt_total 0.
- In RUN, toggle tgl_in 0->1 once with evt_ready=0 -> evt_pulse high one cycle after edge k+2, then pend_cnt=1, evt_valid=1; pulse evt_ready one cycle -> pend_cnt 0, evt_valid 0.
- Five toggles spaced 3 cycles apart, evt_ready=0 -> pend_cnt 4, ovf 1, evt_total 5; pulse clr_ovf -> ovf 0.
- pend_cnt=4 with evt_ready=1 in the same cycle as a detected edge -> pend_cnt 4, ovf 0, evt_total incremented.
- 300 toggles spaced 3 cycles apart, evt_ready=1 -> evt_total 255 (held), ovf 0.
- pend_cnt=3 when rst is driven low for one cycle -> next cycle pend_cnt 0, evt_valid 0, evt_total 0, ovf 0; a toggle during the following INIT is not counted.
